ram_port_arbiter: RTL and testbench

- Shares the single synchronous data-RAM port between two requesters:
  - the CPU control FSM (load/store states);
  - a device requester (I/O or display fetch).
- Round-robin arbitration; every RAM control output is registered.
- Sits between the CPU datapath's RAM address/data muxes and the RAM block, replacing the direct CPU-to-RAM connection.

---
 rtl/ram_port_arbiter_if.sv | 59 +++++
 rtl/ram_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_if
//   Bundles the three sides of the shared data-RAM port: the CPU requester,
//   the device requester and the RAM block itself.
//
//   Cpu*/Dev* : Req/We/Addr/WData from the requester; Gnt/RValid/RData back.
//   Ram*      : En/We/Addr/WData towards the RAM; RData back from the RAM.
//
//   Modports:
//     slave  - the arbiter's view (requests and RAM read data in).
//     master - the environment's view (requesters and the RAM model).
// ---------------------------------------------------------------------------
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // CPU requester
  logic              CpuReq;
  logic              CpuWe;
  logic [ADDR_W-1:0] CpuAddr;
  logic [DATA_W-1:0] CpuWData;
  logic              CpuGnt;
  logic              CpuRValid;
  logic [DATA_W-1:0] CpuRData;

  // Device requester
  logic              DevReq;
  logic              DevWe;
  logic [ADDR_W-1:0] DevAddr;
  logic [DATA_W-1:0] DevWData;
  logic              DevGnt;
  logic              DevRValid;
  logic [DATA_W-1:0] DevRData;

  // RAM port
  logic              RamEn;
  logic              RamWe;
  logic [ADDR_W-1:0] RamAddr;
  logic [DATA_W-1:0] RamWData;
  logic [DATA_W-1:0] RamRData;

  modport slave (
    input  CpuReq, CpuWe, CpuAddr, CpuWData,
    output CpuGnt, CpuRValid, CpuRData,
    input  DevReq, DevWe, DevAddr, DevWData,
    output DevGnt, DevRValid, DevRData,
    output RamEn, RamWe, RamAddr, RamWData,
    input  RamRData
  );

  modport master (
    output CpuReq, CpuWe, CpuAddr, CpuWData,
    input  CpuGnt, CpuRValid, CpuRData,
    output DevReq, DevWe, DevAddr, DevWData,
    input  DevGnt, DevRValid, DevRData,
    input  RamEn, RamWe, RamAddr, RamWData,
    output RamRData
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//   Shares one synchronous data-RAM port between the CPU control FSM and a
//   device requester with round-robin arbitration. Every RAM control output,
//   grant and read-valid is registered; only RamRData -> xRData is
//   combinational.
//
//   Ports:
//     Clk   - system clock, rising edge
//     Reset - asynchronous, active-high
//     bus   - ram_port_arbiter_if.slave (CPU, device and RAM signals)
//
//   Sequence: IDLE samples requests -> ACCESS (Gnt + RAM command valid)
//             -> RDATA (RValid to the owner, reads only) -> IDLE.
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  ram_port_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDATA  = 2'd2
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DEV = 1'b1
  } req_e;

  state_e            state_q,      state_d;
  req_e              last_gnt_q,   last_gnt_d;
  req_e              owner_q,      owner_d;
  logic              ram_en_q,     ram_en_d;
  logic              ram_we_q,     ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q,   ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q,  ram_wdata_d;
  logic              cpu_gnt_q,    cpu_gnt_d;
  logic              dev_gnt_q,    dev_gnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              dev_rvalid_q, dev_rvalid_d;

  // CPU wins when alone, or on a tie when the device was served last.
  logic cpu_wins;
  assign cpu_wins = bus.CpuReq && (!bus.DevReq || (last_gnt_q == REQ_DEV));

  // Next-state and output logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    owner_d      = owner_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_en_d     = 1'b0;   // pulses: low unless explicitly raised
    ram_we_d     = 1'b0;
    cpu_gnt_d    = 1'b0;
    dev_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    dev_rvalid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.CpuReq || bus.DevReq) begin
          owner_d     = cpu_wins ? REQ_CPU : REQ_DEV;
          last_gnt_d  = cpu_wins ? REQ_CPU : REQ_DEV;
          ram_en_d    = 1'b1;
          ram_we_d    = cpu_wins ? bus.CpuWe    : bus.DevWe;
          ram_addr_d  = cpu_wins ? bus.CpuAddr  : bus.DevAddr;
          ram_wdata_d = cpu_wins ? bus.CpuWData : bus.DevWData;
          cpu_gnt_d   = cpu_wins;
          dev_gnt_d   = !cpu_wins;
          state_d     = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        // RAM captures the command at the end of this cycle; a read's data
        // appears on RamRData during the following cycle.
        if (ram_we_q) begin
          state_d = ST_IDLE;
        end else begin
          cpu_rvalid_d = (owner_q == REQ_CPU);
          dev_rvalid_d = (owner_q == REQ_DEV);
          state_d      = ST_RDATA;
        end
      end

      ST_RDATA: state_d = ST_IDLE;

      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      last_gnt_q   <= REQ_DEV;   // CPU wins the first tie
      owner_q      <= REQ_CPU;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      cpu_gnt_q    <= 1'b0;
      dev_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dev_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      owner_q      <= owner_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dev_gnt_q    <= dev_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dev_rvalid_q <= dev_rvalid_d;
    end
  end

  assign bus.RamEn     = ram_en_q;
  assign bus.RamWe     = ram_we_q;
  assign bus.RamAddr   = ram_addr_q;
  assign bus.RamWData  = ram_wdata_q;
  assign bus.CpuGnt    = cpu_gnt_q;
  assign bus.DevGnt    = dev_gnt_q;
  assign bus.CpuRValid = cpu_rvalid_q;
  assign bus.DevRValid = dev_rvalid_q;

  // Read data is shared; each side qualifies it with its own RValid.
  assign bus.CpuRData  = bus.RamRData;
  assign bus.DevRData  = bus.RamRData;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
//   Self-checking bench for ram_port_arbiter. A synchronous RAM model sits on
//   the RAM side. A transaction-level reference predicts, per cycle, grants,
//   RAM commands and read returns from the arbitration rules and a timeline
//   (grant at T+1, read data at T+2, port free again at T+2/T+3).
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Synchronous single-port RAM on the arbiter's RAM side.
  logic [DW-1:0] ram_mem [logic [AW-1:0]];
  always @(posedge Clk) begin
    if (bus.RamEn) begin
      if (bus.RamWe) ram_mem[bus.RamAddr] = bus.RamWData;
      else bus.RamRData <= ram_mem.exists(bus.RamAddr) ? ram_mem[bus.RamAddr] : '0;
    end
  end

  // Bookkeeping
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  int            cyc, free_at, rv_cyc;
  bit            rv_to_cpu;
  logic [DW-1:0] rv_data;
  bit            last_was_cpu;
  bit            e_cgnt, e_dgnt, e_en, e_we, e_crv, e_drv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;

  task automatic model_reset();
    e_cgnt = 0; e_dgnt = 0; e_en = 0; e_we = 0; e_crv = 0; e_drv = 0;
    e_addr = '0; e_wdata = '0; e_rdata = '0;
    last_was_cpu = 0;
    cyc = 0; free_at = 0; rv_cyc = -1;
  endtask

  // Called at each rising edge: inputs seen are those of cycle 'cyc'; the
  // expectations produced are for cycle 'cyc+1'.
  task automatic model_advance();
    int  nxt;
    bit  cpu_wins, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    nxt = cyc + 1;
    e_cgnt = 0; e_dgnt = 0; e_en = 0; e_we = 0; e_crv = 0; e_drv = 0;
    if (nxt == rv_cyc) begin
      e_crv   = rv_to_cpu;
      e_drv   = !rv_to_cpu;
      e_rdata = rv_data;
    end
    if (cyc >= free_at && (bus.CpuReq || bus.DevReq)) begin
      if (bus.CpuReq && bus.DevReq) cpu_wins = !last_was_cpu;
      else                          cpu_wins = bus.CpuReq;
      we = cpu_wins ? bus.CpuWe    : bus.DevWe;
      a  = cpu_wins ? bus.CpuAddr  : bus.DevAddr;
      d  = cpu_wins ? bus.CpuWData : bus.DevWData;
      e_cgnt = cpu_wins; e_dgnt = !cpu_wins;
      e_en = 1; e_we = we; e_addr = a; e_wdata = d;
      last_was_cpu = cpu_wins;
      if (we) begin
        model_mem[a] = d;
        free_at = nxt + 1;
      end else begin
        rv_cyc    = nxt + 1;
        rv_to_cpu = cpu_wins;
        rv_data   = model_mem.exists(a) ? model_mem[a] : '0;
        free_at   = nxt + 2;
      end
    end
    cyc = nxt;
  endtask

  task automatic check_outputs();
    check("cpu_gnt",    bus.CpuGnt,    e_cgnt);
    check("dev_gnt",    bus.DevGnt,    e_dgnt);
    check("ram_en",     bus.RamEn,     e_en);
    check("ram_we",     bus.RamWe,     e_we);
    check("ram_addr",   bus.RamAddr,   e_addr);
    check("ram_wdata",  bus.RamWData,  e_wdata);
    check("cpu_rvalid", bus.CpuRValid, e_crv);
    check("dev_rvalid", bus.DevRValid, e_drv);
    if (e_crv) check("cpu_rdata", bus.CpuRData, e_rdata);
    if (e_drv) check("dev_rdata", bus.DevRData, e_rdata);
  endtask

  // One clock: model updates on the rising edge, DUT sampled on the falling.
  task automatic step();
    @(posedge Clk);
    if (!Reset) model_advance();
    @(negedge Clk);
    check_outputs();
  endtask

  task automatic set_idle();
    bus.CpuReq = 0; bus.CpuWe = 0; bus.CpuAddr = '0; bus.CpuWData = '0;
    bus.DevReq = 0; bus.DevWe = 0; bus.DevAddr = '0; bus.DevWData = '0;
  endtask

  task automatic apply_reset();
    Reset = 1;
    model_reset();
    set_idle();
    step();
    step();
    Reset = 0;
  endtask

  initial begin
    int gnt_who[$];
    logic [AW-1:0] gnt_addr[$];
    int gnt_at[$];
    int n_gnt, n_rv;
    bit c_done, d_done;

    Reset = 1;
    set_idle();
    apply_reset();

    // 1) Reset during a read ACCESS abandons it; re-issue afterwards works.
    bus.CpuReq = 1; bus.CpuWe = 0; bus.CpuAddr = 16'h0010;
    step();
    check("t1_gnt_pre", bus.CpuGnt, 1);
    #1 Reset = 1;
    #1;
    check("t1_en_rst",  bus.RamEn,  0);
    check("t1_gnt_rst", bus.CpuGnt, 0);
    model_reset();
    step();
    step();
    Reset = 0;
    step();
    check("t1_regnt",  bus.CpuGnt,  1);
    check("t1_readdr", bus.RamAddr, 16'h0010);
    bus.CpuReq = 0;
    step();
    check("t1_rv", bus.CpuRValid, 1);
    step();

    // 2) CPU write then read back the same word.
    bus.CpuReq = 1; bus.CpuWe = 1; bus.CpuAddr = 16'h0042; bus.CpuWData = 16'hBEEF;
    step();
    check("t2_wgnt", bus.CpuGnt, 1);
    bus.CpuReq = 0;
    step();
    bus.CpuReq = 1; bus.CpuWe = 0;
    step();
    check("t2_rgnt", bus.CpuGnt, 1);
    bus.CpuReq = 0;
    step();
    check("t2_rv",    bus.CpuRValid, 1);
    check("t2_rdata", bus.CpuRData,  16'hBEEF);
    check("t2_dev",   {bus.DevGnt, bus.DevRValid}, 0);
    step();

    // 3) Continuous contention: grants alternate CPU, DEV, CPU, DEV.
    apply_reset();
    bus.CpuReq = 1; bus.CpuWe = 0; bus.CpuAddr = 16'h0001;
    bus.DevReq = 1; bus.DevWe = 0; bus.DevAddr = 16'h0002;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.CpuGnt) begin gnt_who.push_back(0); gnt_addr.push_back(bus.RamAddr); end
      if (bus.DevGnt) begin gnt_who.push_back(1); gnt_addr.push_back(bus.RamAddr); end
    end
    check("t3_ngnt", gnt_who.size(), 4);
    for (int i = 0; i < 4 && i < gnt_who.size(); i++) begin
      check("t3_who",  gnt_who[i],  i % 2);
      check("t3_addr", gnt_addr[i], (i % 2) ? 16'h0002 : 16'h0001);
    end
    set_idle();
    repeat (3) step();

    // 4) Device write while the CPU is idle.
    bus.DevReq = 1; bus.DevWe = 1; bus.DevAddr = 16'h0100; bus.DevWData = 16'h1234;
    step();
    check("t4_we",    bus.RamWe,    1);
    check("t4_addr",  bus.RamAddr,  16'h0100);
    check("t4_wdata", bus.RamWData, 16'h1234);
    check("t4_gnt",   bus.DevGnt,   1);
    bus.DevReq = 0;
    step();
    check("t4_we_off", bus.RamWe, 0);
    step();

    // 5) CPU drops Req right after being sampled; access still completes.
    bus.CpuReq = 1; bus.CpuWe = 0; bus.CpuAddr = 16'h0100;
    n_gnt = 0; n_rv = 0;
    step();
    n_gnt += int'(bus.CpuGnt); n_rv += int'(bus.CpuRValid);
    bus.CpuReq = 0;
    repeat (4) begin
      step();
      n_gnt += int'(bus.CpuGnt); n_rv += int'(bus.CpuRValid);
    end
    check("t5_ngnt", n_gnt, 1);
    check("t5_nrv",  n_rv,  1);

    // 6) CPU read held 9 cycles: 3 grants, 3 cycles apart.
    apply_reset();
    bus.CpuReq = 1; bus.CpuWe = 0; bus.CpuAddr = 16'h0042;
    for (int i = 1; i <= 9; i++) begin
      if (i == 9) bus.CpuReq = 0;
      step();
      if (bus.CpuGnt) gnt_at.push_back(i);
    end
    check("t6_ngnt", gnt_at.size(), 3);
    for (int i = 1; i < gnt_at.size(); i++) check("t6_space", gnt_at[i] - gnt_at[i-1], 3);
    step();
    // Device request arriving mid-access wins the next IDLE sample.
    bus.CpuReq = 1;
    step();
    check("t6_cpu_first", bus.CpuGnt, 1);
    step();
    bus.DevReq = 1; bus.DevWe = 0; bus.DevAddr = 16'h0100;
    step();
    step();
    check("t6_dev_wins", bus.DevGnt, 1);
    check("t6_cpu_wait", bus.CpuGnt, 0);
    bus.DevReq = 0;
    repeat (3) step();
    check("t6_cpu_next", bus.CpuGnt, 1);
    set_idle();
    repeat (3) step();

    // 7) Randomized traffic from both requesters.
    c_done = 0; d_done = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!bus.CpuReq) begin
        if ($urandom_range(2) == 0) begin
          bus.CpuReq = 1; bus.CpuWe = 1'($urandom_range(1));
          bus.CpuAddr = AW'($urandom_range(7)); bus.CpuWData = DW'($urandom);
          c_done = 0;
        end
      end else if (c_done && $urandom_range(1) == 0) begin
        bus.CpuReq = 0;
      end
      if (!bus.DevReq) begin
        if ($urandom_range(2) == 0) begin
          bus.DevReq = 1; bus.DevWe = 1'($urandom_range(1));
          bus.DevAddr = AW'($urandom_range(7)); bus.DevWData = DW'($urandom);
          d_done = 0;
        end
      end else if (d_done && $urandom_range(1) == 0) begin
        bus.DevReq = 0;
      end
      step();
      if (e_cgnt) c_done = 1;
      if (e_dgnt) d_done = 1;
    end
    set_idle();
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
